// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: DEPTH x WIDTH register file feeding an 8-op ALU through a
// two-stage issue/execute pipeline with writeback forwarding.
// Build option: define ZERO_REG_EN to hardwire register 0 to zero.
module reg_alu_pipe #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    wa,
    input  logic             regwrite,
    input  logic             alusrc,
    input  logic [2:0]       aluctl,
    input  logic [WIDTH-1:0] ext_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       flags,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int unsigned SW = $clog2(WIDTH);

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [WIDTH-1:0] regs [DEPTH];

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_ctl;
    logic [AW-1:0]    s1_wa;
    logic             s1_regwrite;
    logic             s1_alusrc;
    logic [WIDTH-1:0] s1_ext;

    logic [WIDTH-1:0] alu_c;
    logic             carry_c;
    logic             ovf_c;
    logic [WIDTH:0]   wide_c;
    logic [WIDTH-1:0] wb_c;
    logic             wr_en_c;
    logic [WIDTH-1:0] opa_c;
    logic [WIDTH-1:0] opb_c;

    // ALU on the latched stage-1 operands, with carry/borrow and overflow
    always_comb begin
        alu_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        wide_c  = '0;
        case (s1_ctl)
            OP_AND: alu_c = s1_a & s1_b;
            OP_OR:  alu_c = s1_a | s1_b;
            OP_ADD: begin
                wide_c  = {1'b0, s1_a} + {1'b0, s1_b};
                alu_c   = wide_c[WIDTH-1:0];
                carry_c = wide_c[WIDTH];
                ovf_c   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                          (alu_c[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                wide_c  = {1'b0, s1_a} - {1'b0, s1_b};
                alu_c   = wide_c[WIDTH-1:0];
                carry_c = wide_c[WIDTH];
                ovf_c   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                          (alu_c[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_XOR: alu_c = s1_a ^ s1_b;
            OP_SLT: alu_c = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_SHL: alu_c = s1_a << s1_b[SW-1:0];
            OP_SHR: alu_c = s1_a >> s1_b[SW-1:0];
            default: alu_c = '0;
        endcase
    end

    // Writeback value/enable and forwarded operand selection
    always_comb begin
        wb_c    = s1_alusrc ? s1_ext : alu_c;
        wr_en_c = s1_valid && s1_regwrite && !(ZERO_REG && (s1_wa == '0));
        opa_c   = regs[ra1];
        opb_c   = regs[ra2];
        if (wr_en_c && (s1_wa == ra1)) opa_c = wb_c;
        if (wr_en_c && (s1_wa == ra2)) opb_c = wb_c;
        if (ZERO_REG && (ra1 == '0)) opa_c = '0;
        if (ZERO_REG && (ra2 == '0)) opb_c = '0;
    end

    // Debug port reads the architectural register file only
    always_comb begin
        dbg_data = regs[dbg_addr];
        if (ZERO_REG && (dbg_addr == '0)) dbg_data = '0;
    end

    // Register file: written at the execute edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en_c) begin
            regs[s1_wa] <= wb_c;
        end
    end

    // Stage 1: latch operands and control at issue
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_ctl      <= '0;
            s1_wa       <= '0;
            s1_regwrite <= 1'b0;
            s1_alusrc   <= 1'b0;
            s1_ext      <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a        <= opa_c;
                s1_b        <= opb_c;
                s1_ctl      <= aluctl;
                s1_wa       <= wa;
                s1_regwrite <= regwrite;
                s1_alusrc   <= alusrc;
                s1_ext      <= ext_data;
            end
        end
    end

    // Stage 2: register result and flags; hold them when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
            flags      <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                alu_result <= alu_c;
                flags      <= {(alu_c == '0), alu_c[WIDTH-1], carry_c, ovf_c};
            end
        end
    end

endmodule
